// File: rtl/calc_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// calc_cmd_scheduler
//
// Sits between the keypad decoder and the calculator core's command input.
// Key strobes are buffered in a small circular FIFO and handed to the core one
// at a time. A key is only issued while the core reports ready, and each issued
// command is followed by a fixed settle gap before the core's status is looked
// at again. A core error or a watchdog expiry puts the block into a terminal
// fault state that only reset leaves. Both faults are latched as sticky flags
// so they can be shown on the displays.
//
// Handshake semantics:
//   key_valid : one-cycle strobe, key_code is sampled in the same cycle. There
//               is no back-pressure. A key that arrives while the FIFO is full
//               and not being popped is dropped and counted.
//   cmd_valid : one-cycle strobe, cmd is meaningful only while it is high and
//               reads 4'd0 otherwise. The core is never strobed unless it
//               reported ready (2'b10) in the cycle the command was popped.
//
// Parameters:
//   DEPTH   - FIFO entries (power of two, >= 2)
//   SETTLE  - idle cycles after an issued command before status is checked (>= 1)
//   TIMEOUT - max consecutive non-ready cycles in WAIT_READY before a fault (>= 2)
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   key_valid    in   new-key strobe
//   key_code     in   4-bit key (0-9 digits, 10-14 ops/equals, 15 backspace)
//   calc_status  in   core status: 10 ready, 01/11 busy, 00 error
//   cmd          out  command to the core (0 when cmd_valid is low)
//   cmd_valid    out  one-cycle command strobe
//   fifo_count   out  number of buffered keys
//   fifo_full    out  fifo_count == DEPTH
//   drop_count   out  keys lost to a full FIFO, saturating at 255
//   err          out  sticky: core reported error
//   timeout_flag out  sticky: watchdog expired
//
// Every output comes straight from a register (fifo_full is a decode of the
// registered occupancy), so there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module calc_cmd_scheduler #(
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [3:0]               key_code,
    input  logic [1:0]               calc_status,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic [7:0]               drop_count,
    output logic                     err,
    output logic                     timeout_flag
);

    // -------------------------------------------------------------------------
    // Widths
    // -------------------------------------------------------------------------
    localparam int PW = $clog2(DEPTH);        // pointer width
    localparam int CW = PW + 1;               // occupancy width (0..DEPTH)
    localparam int SW = $clog2(SETTLE + 1);   // settle counter holds SETTLE
    localparam int WW = $clog2(TIMEOUT);      // watchdog holds TIMEOUT-1

    // -------------------------------------------------------------------------
    // FSM encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [1:0] ST_READY = 2'b10;
    localparam logic [1:0] ST_ERROR = 2'b00;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2:0]    state;
    logic [2:0]    state_next;

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [SW-1:0] settle_cnt;
    logic [WW-1:0] wd_cnt;

    // -------------------------------------------------------------------------
    // Decodes
    // -------------------------------------------------------------------------
    logic core_ready;
    logic core_error;
    logic fault_hit;
    logic timeout_hit;
    logic enter_err;
    logic fifo_empty;
    logic accepting;
    logic pop;
    logic push;
    logic drop;

    assign core_ready = (calc_status == ST_READY);
    assign core_error = (calc_status == ST_ERROR);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(DEPTH));

    // A core error outranks everything else, in every state but ERR itself.
    assign fault_hit = (state != S_ERR) && core_error;

    // The watchdog value equals the number of non-ready cycles already seen in
    // WAIT_READY, so TIMEOUT-1 here means this is the TIMEOUT-th such cycle.
    assign timeout_hit = (state == S_WAIT) && !core_ready && !core_error &&
                         (wd_cnt == WW'(TIMEOUT - 1));

    assign enter_err = fault_hit || timeout_hit;

    // core_ready already excludes the error code, so a pop can never coincide
    // with a fault transition.
    assign pop = (state == S_IDLE) && !fifo_empty && core_ready;

    // Keys are neither stored nor counted as drops once the block is faulted,
    // including the cycle in which the fault is taken (the FIFO is flushed).
    assign accepting = key_valid && (state != S_ERR) && !enter_err;
    assign push      = accepting && (!fifo_full || pop);
    assign drop      = accepting && fifo_full && !pop;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (fault_hit) begin
            state_next = S_ERR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) state_next = S_ISSUE;
                end
                S_ISSUE: begin
                    state_next = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SW'(1)) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (core_ready)       state_next = S_IDLE;
                    else if (timeout_hit) state_next = S_ERR;
                end
                S_ERR: begin
                    state_next = S_ERR;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // -------------------------------------------------------------------------
    // Settle counter: loaded while the command strobe is out, counts down in
    // SETTLE. The last count (value 1) is the final settle cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state == S_ISSUE) begin
            settle_cnt <= SW'(SETTLE);
        end else if (state == S_SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - SW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog: held at zero outside WAIT_READY, so it is already clear on
    // entry. Counts consecutive non-ready cycles while waiting.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || state != S_WAIT) begin
            wd_cnt <= '0;
        end else if (!core_ready) begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage (data only, no reset needed: occupancy guards every read)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= key_code;
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy. Entering ERR flushes the buffer.
    // Pointers wrap naturally because DEPTH is a power of two.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || enter_err) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Command register: the head is captured at pop time, so cmd and
    // cmd_valid are both high during the ISSUE cycle and cleared after it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd       <= 4'd0;
            cmd_valid <= 1'b0;
        end else begin
            cmd_valid <= pop;
            cmd       <= pop ? mem[rd_ptr] : 4'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Drop counter, saturating
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count <= 8'd0;
        end else if (drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky fault flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            err          <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            if (fault_hit)   err          <= 1'b1;
            if (timeout_hit) timeout_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_calc_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_calc_cmd_scheduler
//
// Directed bench for calc_cmd_scheduler with DEPTH=4, SETTLE=2, TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the registered result of the edge just taken.
// "Cycle n+1" below means "after the step that follows driving cycle n".
// -----------------------------------------------------------------------------
module tb_calc_cmd_scheduler;

    localparam int DEPTH   = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 8;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] calc_status;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [2:0] fifo_count;
    logic       fifo_full;
    logic [7:0] drop_count;
    logic       err;
    logic       timeout_flag;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    calc_cmd_scheduler #(
        .DEPTH   (DEPTH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .calc_status  (calc_status),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .fifo_count   (fifo_count),
        .fifo_full    (fifo_full),
        .drop_count   (drop_count),
        .err          (err),
        .timeout_flag (timeout_flag)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q[$];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Reset: every output zero
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 4'd0;
        calc_status = 2'b10;
        step();
        step();
        reset = 1'b0;
        checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %0b expected 0", cmd_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full: got %0b expected 0", fifo_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout_flag: got %0b expected 0", timeout_flag); end
    endtask

    // -------------------------------------------------------------------------
    // Single key, ready core: strobe in cycle k, cmd_valid only in k+2
    // -------------------------------------------------------------------------
    task automatic test_key_latency();
        calc_status = 2'b10;
        key_valid   = 1'b1;
        key_code    = 4'd7;
        step();                                   // cycle k+1
        key_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL latency_count_k1: got %0d expected 1", fifo_count); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL latency_valid_k1: got %0b expected 0", cmd_valid); end
        step();                                   // cycle k+2
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL latency_valid_k2: got %0b expected 1", cmd_valid); end
        checks++; if (cmd !== 4'd7) begin errors++; $display("FAIL latency_cmd_k2: got %0d expected 7", cmd); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL latency_count_k2: got %0d expected 0", fifo_count); end
        step();                                   // cycle k+3
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL latency_valid_k3: got %0b expected 0", cmd_valid); end
        checks++; if (cmd !== 4'd0) begin errors++; $display("FAIL latency_cmd_k3: got %0d expected 0", cmd); end
        repeat (4) step();                        // back in IDLE
    endtask

    // -------------------------------------------------------------------------
    // Keys 1,2,3,10 back to back: four pulses, in order, 5 cycles apart
    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [3:0] codes [4];
        logic [3:0] e;
        int         last;
        int         pulses;
        codes  = '{4'd1, 4'd2, 4'd3, 4'd10};
        last   = -1;
        pulses = 0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(codes[i]);
        calc_status = 2'b10;
        for (int c = 0; c < 30; c++) begin
            if (c < 4) begin
                key_valid = 1'b1;
                key_code  = codes[c];
            end else begin
                key_valid = 1'b0;
            end
            step();
            if (cmd_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_pulse: got cmd %0d expected no pulse", cmd);
                end else begin
                    e = exp_q.pop_front();
                    if (cmd !== e) begin errors++; $display("FAIL b2b_cmd: got %0d expected %0d", cmd, e); end
                end
                if (last >= 0) begin
                    checks++;
                    if (c - last != 5) begin errors++; $display("FAIL b2b_spacing: got %0d expected 5", c - last); end
                end
                last = c;
                pulses++;
            end
        end
        key_valid = 1'b0;
        checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL b2b_drop: got %0d expected 0", drop_count); end
    endtask

    // -------------------------------------------------------------------------
    // Busy core, 6 keys: full after 4, 2 dropped, first 4 issued on release
    // -------------------------------------------------------------------------
    task automatic test_fifo_full_drop();
        logic [3:0] e;
        int         pulses;
        pulses      = 0;
        calc_status = 2'b01;
        for (int c = 0; c < 6; c++) begin
            key_valid = 1'b1;
            key_code  = 4'(4 + c);
            step();
            if (c == 3) begin
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_after4: got %0b expected 1", fifo_full); end
                checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count4: got %0d expected 4", fifo_count); end
                checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL full_drop_after4: got %0d expected 0", drop_count); end
            end
        end
        key_valid = 1'b0;
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL full_drop_after6: got %0d expected 2", drop_count); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count_after6: got %0d expected 4", fifo_count); end
        exp_q.delete();
        exp_q.push_back(4'd4); exp_q.push_back(4'd5);
        exp_q.push_back(4'd6); exp_q.push_back(4'd7);
        calc_status = 2'b10;
        for (int c = 0; c < 30; c++) begin
            step();
            if (cmd_valid === 1'b1) begin
                checks++;
                pulses++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL full_extra_pulse: got cmd %0d expected no pulse", cmd);
                end else begin
                    e = exp_q.pop_front();
                    if (cmd !== e) begin errors++; $display("FAIL full_cmd: got %0d expected %0d", cmd, e); end
                end
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL full_pulses: got %0d expected 4", pulses); end
    endtask

    // -------------------------------------------------------------------------
    // Full FIFO, push and pop in the same cycle (drop_count is 2 from above)
    // -------------------------------------------------------------------------
    task automatic test_full_push_pop();
        logic [3:0] e;
        int         pulses;
        pulses      = 0;
        calc_status = 2'b01;
        for (int c = 0; c < 4; c++) begin
            key_valid = 1'b1;
            key_code  = 4'(1 + c);
            step();
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pp_full_before: got %0b expected 1", fifo_full); end
        key_valid   = 1'b1;
        key_code    = 4'd11;
        calc_status = 2'b10;
        step();
        key_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL pp_count: got %0d expected 4", fifo_count); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pp_full_after: got %0b expected 1", fifo_full); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL pp_drop: got %0d expected 2", drop_count); end
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL pp_valid: got %0b expected 1", cmd_valid); end
        checks++; if (cmd !== 4'd1) begin errors++; $display("FAIL pp_cmd: got %0d expected 1", cmd); end
        exp_q.delete();
        exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        exp_q.push_back(4'd4); exp_q.push_back(4'd11);
        for (int c = 0; c < 30; c++) begin
            step();
            if (cmd_valid === 1'b1) begin
                checks++;
                pulses++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL pp_extra_pulse: got cmd %0d expected no pulse", cmd);
                end else begin
                    e = exp_q.pop_front();
                    if (cmd !== e) begin errors++; $display("FAIL pp_drain_cmd: got %0d expected %0d", cmd, e); end
                end
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL pp_pulses: got %0d expected 4", pulses); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL pp_drained: got %0d expected 0", fifo_count); end
    endtask

    // -------------------------------------------------------------------------
    // Reset during ISSUE: strobe dropped, queued key lost
    // -------------------------------------------------------------------------
    task automatic test_reset_mid_issue();
        int stray;
        stray       = 0;
        calc_status = 2'b10;
        key_valid   = 1'b1;
        key_code    = 4'd9;
        step();                                   // k+1: pop 9, push 5
        key_code = 4'd5;
        step();                                   // k+2: ISSUE
        key_valid = 1'b0;
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd9) begin errors++; $display("FAIL mid_issue_pulse: got valid=%0b cmd=%0d expected valid=1 cmd=9", cmd_valid, cmd); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (cmd_valid !== 1'b0 || cmd !== 4'd0) begin errors++; $display("FAIL mid_issue_clear: got valid=%0b cmd=%0d expected 0 0", cmd_valid, cmd); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_issue_count: got %0d expected 0", fifo_count); end
        for (int c = 0; c < 8; c++) begin
            step();
            if (cmd_valid === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_issue_lost_key: got %0d pulses expected 0", stray); end
    endtask

    // -------------------------------------------------------------------------
    // Watchdog: busy after issue, ERR on 8th non-ready WAIT cycle (k+13)
    // -------------------------------------------------------------------------
    task automatic test_timeout();
        int stray;
        stray = 0;
        for (int c = 0; c < 13; c++) begin
            calc_status = (c < 2) ? 2'b10 : 2'b01;
            if (c == 0)      begin key_valid = 1'b1; key_code = 4'd5; end
            else if (c == 3) begin key_valid = 1'b1; key_code = 4'd8; end
            else if (c == 4) begin key_valid = 1'b1; key_code = 4'd9; end
            else             key_valid = 1'b0;
            step();
            if (c + 1 == 2) begin
                checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd5) begin errors++; $display("FAIL to_issue: got valid=%0b cmd=%0d expected valid=1 cmd=5", cmd_valid, cmd); end
            end
            if (c + 1 == 12) begin
                checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL to_early: got %0b expected 0", timeout_flag); end
                checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL to_queued: got %0d expected 2", fifo_count); end
            end
        end
        checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag: got %0b expected 1", timeout_flag); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL to_flush: got %0d expected 0", fifo_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err: got %0b expected 0", err); end
        calc_status = 2'b10;
        for (int c = 0; c < 10; c++) begin
            key_valid = (c % 2 == 0);
            key_code  = 4'd2;
            step();
            if (cmd_valid === 1'b1 || fifo_count !== 3'd0) stray++;
        end
        key_valid = 1'b0;
        checks++; if (stray != 0) begin errors++; $display("FAIL to_terminal: got %0d active cycles expected 0", stray); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL to_no_drops: got %0d expected 0", drop_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL to_reset_flag: got %0b expected 0", timeout_flag); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL to_reset_count: got %0d expected 0", fifo_count); end
    endtask

    // -------------------------------------------------------------------------
    // Core error during SETTLE with 2 keys queued, then mid-run reset
    // -------------------------------------------------------------------------
    task automatic test_error_priority();
        int stray;
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            calc_status = (c == 3) ? 2'b00 : 2'b10;
            if (c == 0)      begin key_valid = 1'b1; key_code = 4'd3; end
            else if (c == 1) begin key_valid = 1'b1; key_code = 4'd4; end
            else if (c == 2) begin key_valid = 1'b1; key_code = 4'd6; end
            else             key_valid = 1'b0;
            step();
            if (c + 1 == 2) begin
                checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd3) begin errors++; $display("FAIL ep_issue: got valid=%0b cmd=%0d expected valid=1 cmd=3", cmd_valid, cmd); end
            end
            if (c + 1 == 3) begin
                checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL ep_queued: got %0d expected 2", fifo_count); end
            end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ep_err: got %0b expected 1", err); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ep_flush: got %0d expected 0", fifo_count); end
        checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL ep_timeout_flag: got %0b expected 0", timeout_flag); end
        calc_status = 2'b10;
        for (int c = 0; c < 12; c++) begin
            key_valid = (c % 3 != 2);
            key_code  = 4'(c);
            step();
            if (cmd_valid === 1'b1 || fifo_count !== 3'd0) stray++;
        end
        key_valid = 1'b0;
        checks++; if (stray != 0) begin errors++; $display("FAIL ep_terminal: got %0d active cycles expected 0", stray); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ep_sticky: got %0b expected 1", err); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL ep_no_drops: got %0d expected 0", drop_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ep_reset_err: got %0b expected 0", err); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ep_reset_valid: got %0b expected 0", cmd_valid); end
        test_key_latency();
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_key_latency();
        test_back_to_back();
        test_fifo_full_drop();
        test_full_push_pop();
        test_reset_mid_issue();
        test_timeout();
        test_error_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
